// File: rtl/hazard_unit_pkg.sv
// Shared types for the hazard unit: scoreboard entry layout and forwarding-select encoding.
package hazard_unit_pkg;

  // Entry rd field is sized for the widest supported register index; narrower indices are zero-extended.
  localparam int unsigned RD_W   = 8;
  localparam int unsigned SEL_RF = 0;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer search for one source operand; yields a hazard flag and the EX forwarding select.
module hazard_match
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned SEL_W      = 2
) (
  input  logic [REG_AW-1:0]           src_i,
  input  logic                        src_used_i,
  input  sb_entry_t [DEPTH-2:0]       sb_i,
  output logic                        hazard_c_o,
  output logic [SEL_W-1:0]            sel_c_o
);

  logic hit;
  logic hit_load;
  int   hit_p;

  always_comb begin
    hit        = 1'b0;
    hit_load   = 1'b0;
    hit_p      = 0;
    hazard_c_o = 1'b0;
    sel_c_o    = SEL_W'(SEL_RF);

    // Scan oldest to youngest so the lowest matching index is the one that sticks.
    for (int j = int'(DEPTH) - 2; j >= 0; j--) begin
      if (sb_i[j].valid && (sb_i[j].rd == RD_W'(src_i))) begin
        hit      = 1'b1;
        hit_load = sb_i[j].is_load;
        hit_p    = j + 1;
      end
    end

    if (!src_used_i || (src_i == '0)) begin
      hit = 1'b0;
    end

    if (hit) begin
      if (FWD_EN != 0) begin
        if (hit_load && (hit_p < int'(LOAD_STAGE))) begin
          hazard_c_o = 1'b1;
        end else begin
          sel_c_o = SEL_W'(hit_p);
        end
      end else begin
        hazard_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control: in-flight destination scoreboard, ID stall/flush,
// registered EX operand selects and a saturating stall-cycle counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned SEL_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              branch_taken,
  output logic              stall,
  output logic              flush_id,
  output logic [SEL_W-1:0]  ex_fwd_rs,
  output logic [SEL_W-1:0]  ex_fwd_rt,
  output logic [15:0]       stall_cnt
);

  // The WB entry (index DEPTH-1) is never consulted because the register file is write-first,
  // so only indices 0..DEPTH-2 are held.
  sb_entry_t [DEPTH-2:0] sb_q, sb_d;
  logic [SEL_W-1:0]      ex_fwd_rs_q, ex_fwd_rs_d;
  logic [SEL_W-1:0]      ex_fwd_rt_q, ex_fwd_rt_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  logic             haz_rs, haz_rt;
  logic [SEL_W-1:0] sel_rs, sel_rt;
  logic             track;
  logic             advance;

  hazard_match #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .FWD_EN(FWD_EN), .SEL_W(SEL_W)
  ) u_match_rs (
    .src_i(id_rs), .src_used_i(id_rs_used), .sb_i(sb_q), .hazard_c_o(haz_rs), .sel_c_o(sel_rs)
  );

  hazard_match #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .FWD_EN(FWD_EN), .SEL_W(SEL_W)
  ) u_match_rt (
    .src_i(id_rt), .src_used_i(id_rt_used), .sb_i(sb_q), .hazard_c_o(haz_rt), .sel_c_o(sel_rt)
  );

  always_comb begin
    stall       = 1'b0;
    flush_id    = 1'b0;
    track       = 1'b0;
    advance     = 1'b0;
    sb_d        = '0;
    ex_fwd_rs_d = SEL_W'(SEL_RF);
    ex_fwd_rt_d = SEL_W'(SEL_RF);
    stall_cnt_d = stall_cnt_q;

    // A taken branch overrides any stall; both are held low while in reset.
    if (!rst) begin
      flush_id = branch_taken;
      stall    = id_valid & (haz_rs | haz_rt) & ~branch_taken;
    end

    track   = id_valid & id_wr_en & (id_rd != '0);
    advance = id_valid & ~stall & ~branch_taken;

    for (int i = 1; i < int'(DEPTH) - 1; i++) begin
      sb_d[i] = sb_q[i-1];
    end
    if (track && !stall && !branch_taken) begin
      sb_d[0].valid   = 1'b1;
      sb_d[0].rd      = RD_W'(id_rd);
      sb_d[0].is_load = id_is_load;
    end

    if (advance) begin
      ex_fwd_rs_d = sel_rs;
      ex_fwd_rt_d = sel_rt;
    end

    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q        <= '0;
      ex_fwd_rs_q <= SEL_W'(SEL_RF);
      ex_fwd_rt_q <= SEL_W'(SEL_RF);
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      ex_fwd_rs_q <= ex_fwd_rs_d;
      ex_fwd_rt_q <= ex_fwd_rt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_fwd_rs = ex_fwd_rs_q;
  assign ex_fwd_rt = ex_fwd_rt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a vector table on the forwarding instance plus hand sequences
// for stall-only mode and asynchronous reset.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, branch_taken;
  logic [4:0] id_rs, id_rt, id_rd;

  logic        stall, flush_id;
  logic [1:0]  ex_fwd_rs, ex_fwd_rt;
  logic [15:0] stall_cnt;
  logic        nf_stall, nf_flush_id;
  logic [1:0]  nf_ex_fwd_rs, nf_ex_fwd_rt;
  logic [15:0] nf_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .branch_taken(branch_taken), .stall(stall), .flush_id(flush_id),
    .ex_fwd_rs(ex_fwd_rs), .ex_fwd_rt(ex_fwd_rt), .stall_cnt(stall_cnt)
  );

  hazard_unit #(.FWD_EN(0)) dut_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .branch_taken(branch_taken), .stall(nf_stall), .flush_id(nf_flush_id),
    .ex_fwd_rs(nf_ex_fwd_rs), .ex_fwd_rt(nf_ex_fwd_rt), .stall_cnt(nf_stall_cnt)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       rsu, rtu;
    logic [4:0] rd;
    logic       we, ld, br;
    int         e_stall, e_flush, e_frs, e_frt, e_cnt;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic v, input int rs, input int rt, input logic rsu,
                              input logic rtu, input int rd, input logic we, input logic ld,
                              input logic br, input int es, input int ef, input int efrs,
                              input int efrt, input int ecnt);
    vec_t r;
    r.v = v; r.rs = 5'(rs); r.rt = 5'(rt); r.rsu = rsu; r.rtu = rtu; r.rd = 5'(rd);
    r.we = we; r.ld = ld; r.br = br;
    r.e_stall = es; r.e_flush = ef; r.e_frs = efrs; r.e_frt = efrt; r.e_cnt = ecnt;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_rs_used = x.rsu; id_rt_used = x.rtu;
    id_rd = x.rd; id_wr_en = x.we; id_is_load = x.ld; branch_taken = x.br;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic reset_pulse();
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    //            v  rs rt rsu rtu rd we ld br  stall flush frs frt cnt
    vecs[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);   // add r3
    vecs[1]  = mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 1, 0, 0);   // sub r4,r3 -> MEM
    vecs[2]  = mk(1, 1, 3, 1, 1, 5, 1, 0, 0, 0, 0, 0, 2, 0);   // r3 one apart -> WB
    vecs[3]  = mk(1, 4, 5, 1, 1, 6, 1, 0, 0, 0, 0, 2, 1, 0);   // both sources, different entries
    vecs[4]  = mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);   // lw r7
    vecs[5]  = mk(1, 7, 6, 1, 1, 8, 1, 0, 0, 1, 0, 0, 0, 1);   // load-use stall
    vecs[6]  = mk(1, 7, 6, 1, 1, 8, 1, 0, 0, 0, 0, 2, 0, 1);   // retry, r6 now in WB
    vecs[7]  = mk(1, 8, 8, 1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1);   // writes r0: untracked
    vecs[8]  = mk(1, 0, 8, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1);   // r0 read, rt unused
    vecs[9]  = mk(1, 1, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1);   // r7 writer #1
    vecs[10] = mk(1, 1, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1);   // r7 writer #2
    vecs[11] = mk(1, 7, 7, 1, 1, 10, 1, 0, 0, 0, 0, 1, 1, 1);  // youngest wins
    vecs[12] = mk(1, 0, 0, 0, 0, 11, 1, 1, 0, 0, 0, 0, 0, 1);  // lw r11
    vecs[13] = mk(1, 11, 1, 1, 1, 12, 1, 0, 1, 0, 1, 0, 0, 1); // hazard + branch: flush wins
    vecs[14] = mk(1, 11, 12, 1, 1, 13, 1, 0, 0, 0, 0, 2, 0, 1); // r12 was squashed
    vecs[15] = mk(0, 13, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // invalid slot
    vecs[16] = mk(1, 0, 0, 0, 0, 14, 1, 1, 0, 0, 0, 0, 0, 1);  // lw r14
    vecs[17] = mk(1, 13, 14, 1, 1, 15, 1, 0, 0, 1, 0, 0, 0, 2); // rt load-use, rs past window
    vecs[18] = mk(1, 13, 14, 1, 1, 15, 1, 0, 0, 0, 0, 0, 2, 2);

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", int'(stall), 0);
    chk("rst.fwd_rs", int'(ex_fwd_rs), 0);
    chk("rst.cnt", int'(stall_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d.stall", i), int'(stall), vecs[i].e_stall);
      chk($sformatf("v%0d.flush", i), int'(flush_id), vecs[i].e_flush);
      @(posedge clk); #1;
      chk($sformatf("v%0d.fwd_rs", i), int'(ex_fwd_rs), vecs[i].e_frs);
      chk($sformatf("v%0d.fwd_rt", i), int'(ex_fwd_rt), vecs[i].e_frt);
      chk($sformatf("v%0d.cnt", i), int'(stall_cnt), vecs[i].e_cnt);
    end

    // Load-use in stall-only mode: two stall cycles, selects stay 0.
    reset_pulse();
    drive(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("nf.lu.stall0", int'(nf_stall), 1);
    chk("fw.lu.stall0", int'(stall), 1);
    @(posedge clk); #1;
    chk("nf.lu.stall1", int'(nf_stall), 1);
    chk("nf.lu.cnt1", int'(nf_stall_cnt), 1);
    chk("nf.lu.fwd1", int'(nf_ex_fwd_rs), 0);
    chk("fw.lu.stall1", int'(stall), 0);
    @(posedge clk); #1;
    chk("nf.lu.stall2", int'(nf_stall), 0);
    chk("nf.lu.cnt2", int'(nf_stall_cnt), 2);
    chk("fw.lu.fwd2", int'(ex_fwd_rs), 2);
    chk("fw.lu.cnt2", int'(stall_cnt), 1);
    @(posedge clk); #1;
    chk("nf.lu.fwd3", int'(nf_ex_fwd_rs), 0);
    chk("nf.lu.cnt3", int'(nf_stall_cnt), 2);
    idle();

    // Asynchronous reset while the stall-only instance is mid-stall.
    reset_pulse();
    drive(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0));   // add r3
    @(posedge clk); #1;
    drive(mk(1, 3, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));   // lw r5,(r3)
    #1;
    chk("ar.nf_stall_pre", int'(nf_stall), 1);
    @(posedge clk); #1;
    chk("ar.fwd_pre", int'(ex_fwd_rs), 1);
    chk("ar.nf_cnt_pre", int'(nf_stall_cnt), 1);
    chk("ar.nf_stall_mid", int'(nf_stall), 1);
    rst = 1'b1;
    branch_taken = 1'b1;
    #1;
    chk("ar.nf_stall", int'(nf_stall), 0);
    chk("ar.nf_cnt", int'(nf_stall_cnt), 0);
    chk("ar.fwd_rs", int'(ex_fwd_rs), 0);
    chk("ar.flush", int'(flush_id), 0);
    chk("ar.nf_flush", int'(nf_flush_id), 0);
    #2;
    rst = 1'b0;
    drive(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0));   // reader of r3 and r5
    #1;
    chk("ar.post_stall", int'(stall), 0);
    chk("ar.post_nf_stall", int'(nf_stall), 0);
    @(posedge clk); #1;
    chk("ar.post_fwd_rs", int'(ex_fwd_rs), 0);
    chk("ar.post_fwd_rt", int'(ex_fwd_rt), 0);
    chk("ar.post_cnt", int'(stall_cnt), 0);
    idle();

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard-detection and forwarding controller for the pipelined MIPS datapath. It tracks the destination registers of in-flight instructions in a DEPTH-entry shift scoreboard (EX, MEM, WB, …). It stalls the ID stage on unresolvable read-after-write hazards and flushes it on a taken branch. It delivers registered forwarding selects to the EX-stage operand muxes. A saturating counter records stall cycles for performance debug.

## Interface
- REG_AW, 5, register-index width
- DEPTH, 3, scoreboard entries after ID (index 0 = EX … DEPTH-1 = WB), ≥2
- LOAD_STAGE, 2, lowest scoreboard index at which load data can be forwarded
- FWD_EN, 1, 1 = forwarding enabled, 0 = stall-only mode
- SEL_W, $clog2(DEPTH), forwarding-select width (derived)
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs / id_rt  in  REG_AW  source register indices
- id_rs_used / id_rt_used  in  1  source actually read
- id_rd  in  REG_AW  destination index (after RegDst mux)
- id_wr_en  in  1  instruction writes the register file
- id_is_load  in  1  instruction is a load
- branch_taken  in  1  branch/jump resolved taken this cycle
- stall  out  1  hold PC and IF/ID; inject a bubble into EX
- flush_id  out  1  squash the IF/ID register contents
- ex_fwd_rs / ex_fwd_rt  out  SEL_W  registered EX operand selects: 0 = register file, k = value held at scoreboard index k
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Each entry holds {valid, rd, is_load}.
- An ID instruction is tracked only when id_valid & id_wr_en & id_rd≠0.
- Scoreboard advance happens every cycle. Entry i+1 ← entry i. Entry 0 ← the tracked ID instruction, or a bubble (valid=0) when stall or branch_taken.
- The register file is write-first. A producer at index DEPTH-1 is therefore invisible to hazard logic.
- Match search: for each used source ≠0, find the youngest (lowest index) valid entry j ≤ DEPTH-2 with rd == source. The producer will be at p = j+1 when the consumer is in EX.
- FWD_EN=1:
  - Stall if entry j is a load and p < LOAD_STAGE.
  - Otherwise the select is p.
- FWD_EN=0: stall on any match; the select is always 0.
- stall = id_valid & (hazard on rs or rt) & ~branch_taken. A taken branch overrides the stall.
- flush_id = branch_taken.
- ex_fwd_*:
  - Loaded with the computed selects when the ID instruction advances (no stall, no flush).
  - Cleared to 0 on stall or flush, because a bubble enters EX.
- stall_cnt increments on each cycle with stall=1 and saturates at 16'hFFFF.

## Timing
- stall and flush_id are combinational from the inputs and the scoreboard, valid in the same cycle.
- ex_fwd_* and the scoreboard update on the rising clk edge. The selects are valid for the entire EX cycle of the consumer.
- Load-use with default parameters costs exactly one stall cycle. The consumer then forwards from index 2 (WB).
- Back-to-back ALU dependency costs zero stalls, forwarding from index 1 (MEM).
- Reset:
  - All entries go invalid, ex_fwd_*=0, stall_cnt=0.
  - stall=0 and flush_id=0 while rst is held.
  - Asynchronous assertion mid-operation discards all tracking immediately.
- Simultaneous stall hazard and branch_taken: flush wins, stall=0, and stall_cnt does not increment.
- Both sources matching different entries: each select is resolved independently.
- A stall from either source stalls the whole instruction.

## Structure
- A shared package holds the scoreboard entry struct {valid, rd, is_load} and the select encoding constant SEL_RF=0.
- One sub-module, hazard_match: a combinational youngest-match search per source port, instantiated twice (rs, rt).
- The scoreboard shift register, stall/flush logic, select registers and counter live in the top module.

## Test plan
- ALU chain: add r3 then sub r4,r3 → stall=0, ex_fwd_rs=1 in the sub's EX cycle. With one independent instruction between them → ex_fwd_rs=2.
- Load-use: lw r5 then add r6,r5 → stall=1 for exactly one cycle, stall_cnt=1, then ex_fwd_rs=2. With FWD_EN=0 the same sequence stalls 2 cycles and ex_fwd stays 0.
- r0 and unused sources: producer rd=0, or consumer rt_used=0 with a matching rt → no stall, select 0.
- Youngest wins: r7 written by two consecutive instructions, then read → ex_fwd=1 (youngest), not 2.
- Flush priority: load-use hazard present while branch_taken=1 → stall=0, flush_id=1, entry 0 is a bubble, stall_cnt unchanged.
- Reset: assert rst mid-stall → stall drops asynchronously, ex_fwd_*=0, stall_cnt=0. A previously matching reader issued after release sees no hazard.
